pot_scanner: RTL

POT_SCANNER -- requirements
Module: pot_scanner

---
 rtl/pot_scanner.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/pot_scanner.sv
// Round-robin scanner for a bank of MCP300x-style SPI ADCs. It keeps a
// hysteresis-filtered copy of every pot and pulses out each stored change.
module pot_scanner #(
    parameter int  NUM_ADCS   = 2,
    parameter int  CH_PER_ADC = 8,
    parameter int  ADC_BITS   = 10,
    parameter int  CLK_DIV    = 4,
    parameter int  HYST       = 4,
    localparam int NUM_POTS   = NUM_ADCS * CH_PER_ADC,
    localparam int IW         = (NUM_POTS > 1) ? $clog2(NUM_POTS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         scan_enable,
    input  logic                         cipo,
    output logic                         copi,
    output logic                         dclk,
    output logic [NUM_ADCS-1:0]          cs_n,
    output logic [NUM_POTS*ADC_BITS-1:0] pot_values,
    output logic                         change_valid,
    output logic [IW-1:0]                change_index,
    output logic [ADC_BITS-1:0]          change_value,
    output logic                         scan_done
);
    localparam int FRAME_PERIODS = 6 + ADC_BITS;
    localparam int DATA_START    = 6;
    localparam int PW            = $clog2(FRAME_PERIODS);
    localparam int DW            = $clog2(2 * CLK_DIV);
    localparam int CW            = (NUM_ADCS > 1) ? $clog2(NUM_ADCS) : 1;
    localparam logic [ADC_BITS:0] HYST_W = (ADC_BITS + 1)'(HYST);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, UPDATE, GAP} state_t;

    state_t                state_reg, state_next;
    logic [DW-1:0]         div_reg, div_next;
    logic [PW-1:0]         period_reg, period_next;
    logic                  dclk_reg, dclk_next;
    logic                  copi_reg, copi_next;
    logic [NUM_ADCS-1:0]   cs_n_reg, cs_n_next;
    logic [ADC_BITS-1:0]   shift_reg, shift_next;
    logic [CW-1:0]         chip_reg, chip_next, chip_adv;
    logic [2:0]            ch_reg, ch_next, ch_adv;
    logic                  change_valid_reg, change_valid_next;
    logic [IW-1:0]         change_index_reg, change_index_next;
    logic [ADC_BITS-1:0]   change_value_reg, change_value_next;
    logic                  scan_done_reg, scan_done_next;
    logic [ADC_BITS-1:0]   pot_mem [NUM_POTS];
    logic [NUM_POTS-1:0]   valid_reg;

    logic [IW-1:0]         p_cur;
    logic [ADC_BITS-1:0]   stored;
    logic [ADC_BITS:0]     diff, abs_diff;
    logic                  write_en;

    // Command word: start, single-ended, channel[2:0]; zeros afterwards.
    function automatic logic cmd_bit(input logic [PW-1:0] period, input logic [2:0] ch);
        case (period)
            PW'(0), PW'(1): cmd_bit = 1'b1;
            PW'(2):         cmd_bit = ch[2];
            PW'(3):         cmd_bit = ch[1];
            PW'(4):         cmd_bit = ch[0];
            default:        cmd_bit = 1'b0;
        endcase
    endfunction

    function automatic logic [NUM_ADCS-1:0] chip_sel_n(input logic [CW-1:0] chip);
        chip_sel_n       = '1;
        chip_sel_n[chip] = 1'b0;
    endfunction

    assign p_cur = IW'(int'(chip_reg) * CH_PER_ADC + int'(ch_reg));

    always_comb begin
        ch_adv   = ch_reg + 3'd1;
        chip_adv = chip_reg;
        if (ch_reg == 3'(CH_PER_ADC - 1)) begin
            ch_adv   = 3'd0;
            chip_adv = (chip_reg == CW'(NUM_ADCS - 1)) ? '0 : chip_reg + 1'b1;
        end
    end

    // The decision is taken as the frame ends so the pulse lands in UPDATE.
    assign stored   = pot_mem[p_cur];
    assign diff     = {1'b0, shift_reg} - {1'b0, stored};
    assign abs_diff = diff[ADC_BITS] ? (~diff + 1'b1) : diff;
    assign write_en = !valid_reg[p_cur] || ((shift_reg != stored) && (abs_diff >= HYST_W));

    always_comb begin
        state_next        = state_reg;
        div_next          = div_reg;
        period_next       = period_reg;
        dclk_next         = dclk_reg;
        copi_next         = copi_reg;
        cs_n_next         = cs_n_reg;
        shift_next        = shift_reg;
        chip_next         = chip_reg;
        ch_next           = ch_reg;
        change_valid_next = 1'b0;
        scan_done_next    = 1'b0;
        change_index_next = change_index_reg;
        change_value_next = change_value_reg;
        case (state_reg)
            IDLE: begin
                if (scan_enable) begin
                    state_next  = SETUP;
                    div_next    = '0;
                    period_next = '0;
                    copi_next   = 1'b1;
                    cs_n_next   = chip_sel_n(chip_reg);
                end
            end
            SETUP: begin
                if (div_reg == DW'(CLK_DIV - 1)) begin
                    state_next = SHIFT;
                    div_next   = '0;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            SHIFT: begin
                if (div_reg == DW'(CLK_DIV - 1)) begin
                    div_next = '0;
                    if (!dclk_reg) begin
                        dclk_next = 1'b1;
                        if (period_reg >= PW'(DATA_START))
                            shift_next = {shift_reg[ADC_BITS-2:0], cipo};
                    end else begin
                        dclk_next = 1'b0;
                        if (period_reg == PW'(FRAME_PERIODS - 1)) begin
                            state_next     = UPDATE;
                            cs_n_next      = '1;
                            copi_next      = 1'b0;
                            scan_done_next = (p_cur == IW'(NUM_POTS - 1));
                            if (write_en) begin
                                change_valid_next = 1'b1;
                                change_index_next = p_cur;
                                change_value_next = shift_reg;
                            end
                        end else begin
                            period_next = period_reg + 1'b1;
                            copi_next   = cmd_bit(period_reg + 1'b1, ch_reg);
                        end
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            UPDATE: begin
                state_next = GAP;
                div_next   = '0;
            end
            GAP: begin
                if (div_reg == DW'(2 * CLK_DIV - 1)) begin
                    div_next  = '0;
                    chip_next = chip_adv;
                    ch_next   = ch_adv;
                    if (scan_enable) begin
                        state_next  = SETUP;
                        period_next = '0;
                        copi_next   = 1'b1;
                        cs_n_next   = chip_sel_n(chip_adv);
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            div_reg          <= '0;
            period_reg       <= '0;
            dclk_reg         <= 1'b0;
            copi_reg         <= 1'b0;
            cs_n_reg         <= '1;
            shift_reg        <= '0;
            chip_reg         <= '0;
            ch_reg           <= '0;
            change_valid_reg <= 1'b0;
            change_index_reg <= '0;
            change_value_reg <= '0;
            scan_done_reg    <= 1'b0;
            valid_reg        <= '0;
            for (int i = 0; i < NUM_POTS; i++) pot_mem[i] <= '0;
        end else begin
            state_reg        <= state_next;
            div_reg          <= div_next;
            period_reg       <= period_next;
            dclk_reg         <= dclk_next;
            copi_reg         <= copi_next;
            cs_n_reg         <= cs_n_next;
            shift_reg        <= shift_next;
            chip_reg         <= chip_next;
            ch_reg           <= ch_next;
            change_valid_reg <= change_valid_next;
            change_index_reg <= change_index_next;
            change_value_reg <= change_value_next;
            scan_done_reg    <= scan_done_next;
            if (state_reg == UPDATE && change_valid_reg) begin
                pot_mem[change_index_reg]   <= change_value_reg;
                valid_reg[change_index_reg] <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_POTS; gi++) begin : g_flat
            assign pot_values[gi*ADC_BITS +: ADC_BITS] = pot_mem[gi];
        end
    endgenerate

    assign copi         = copi_reg;
    assign dclk         = dclk_reg;
    assign cs_n         = cs_n_reg;
    assign change_valid = change_valid_reg;
    assign change_index = change_index_reg;
    assign change_value = change_value_reg;
    assign scan_done    = scan_done_reg;
endmodule
